// File: rtl/lsu_seq.sv
// Multi-cycle load/store unit: byte-enable generation, store alignment, load extraction.
// Optional LSU_MISALIGN_EN macro enables two-beat servicing of word-crossing accesses.
module lsu_seq #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [AW-1:0]     req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_err
);
   localparam int unsigned BYTES = XLEN / 8;
   localparam int unsigned OFF_W = $clog2(BYTES);
   localparam int unsigned IDX_W = $clog2(XLEN);

   typedef enum logic [2:0] {StIdle, StReq0, StWait0, StReq1, StWait1, StResp} state_e;

   state_e             state_q, state_d;
   logic               we_q, we_d;
   logic [3:0]         size_q, size_d;
   logic               sgn_q, sgn_d;
   logic [OFF_W-1:0]   off_q, off_d;
   logic               mem_req_q, mem_req_d;
   logic               mem_we_q, mem_we_d;
   logic [AW-1:0]      mem_addr_q, mem_addr_d;
   logic [BYTES-1:0]   mem_be_q, mem_be_d;
   logic [XLEN-1:0]    mem_wdata_q, mem_wdata_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_err_q, rsp_err_d;
   logic [XLEN-1:0]    rsp_rdata_q, rsp_rdata_d;
`ifdef LSU_MISALIGN_EN
   logic               split_q, split_d;
   logic [BYTES-1:0]   be_hi_q, be_hi_d;
   logic [XLEN-1:0]    wdata_hi_q, wdata_hi_d;
   logic [XLEN-1:0]    lo_q, lo_d;
`endif

   logic               dec_legal, dec_sgn, dec_split, reject;
   logic [3:0]         dec_size;
   logic [OFF_W-1:0]   req_off;
   logic [2*BYTES-1:0] mask_base;
   logic [2*XLEN-1:0]  ld_word;
   logic [XLEN-1:0]    ld_field, ld_ext;
   logic [IDX_W-1:0]   msb_idx;

   assign req_off   = req_addr[OFF_W-1:0];
   assign req_ready = (state_q == StIdle);

   always_comb begin
      dec_legal = 1'b1;
      dec_size  = 4'd1;
      dec_sgn   = 1'b0;
      case (req_funct3)
         3'b000:  begin dec_size = 4'd1; dec_sgn = 1'b1; end
         3'b001:  begin dec_size = 4'd2; dec_sgn = 1'b1; end
         3'b010:  begin dec_size = 4'd4; dec_sgn = 1'b1; end
         3'b011:  begin dec_size = 4'd8; dec_legal = (XLEN == 64); end
         3'b100:  begin dec_size = 4'd1; dec_legal = !req_we; end
         3'b101:  begin dec_size = 4'd2; dec_legal = !req_we; end
         3'b110:  begin dec_size = 4'd4; dec_legal = !req_we && (XLEN == 64); end
         default: dec_legal = 1'b0;
      endcase
      dec_split = (int'(req_off) + int'(dec_size)) > int'(BYTES);
      reject    = !dec_legal;
`ifndef LSU_MISALIGN_EN
      reject    = reject | dec_split;
`endif
      mask_base = '0;
      for (int i = 0; i < int'(BYTES); i++) begin
         if (i < int'(dec_size)) mask_base[i] = 1'b1;
      end
   end

   // Load extraction: low beat in WAIT0 comes straight off the bus, high beat in WAIT1.
   always_comb begin
      ld_word = {{XLEN{1'b0}}, mem_rdata};
`ifdef LSU_MISALIGN_EN
      if (state_q == StWait1) ld_word = {mem_rdata, lo_q};
`endif
      ld_field = XLEN'(ld_word >> {off_q, 3'b000});
      msb_idx  = IDX_W'(8 * int'(size_q) - 1);
      ld_ext   = ld_field;
      for (int i = 0; i < int'(XLEN); i++) begin
         if (i >= 8 * int'(size_q)) ld_ext[i] = sgn_q & ld_field[msb_idx];
      end
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      sgn_d       = sgn_q;
      off_d       = off_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
`ifdef LSU_MISALIGN_EN
      split_d     = split_q;
      be_hi_d     = be_hi_q;
      wdata_hi_d  = wdata_hi_q;
      lo_d        = lo_q;
`endif
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               we_d   = req_we;
               size_d = dec_size;
               sgn_d  = dec_sgn;
               off_d  = req_off;
`ifdef LSU_MISALIGN_EN
               split_d    = dec_split;
               be_hi_d    = BYTES'((mask_base << req_off) >> BYTES);
               wdata_hi_d = XLEN'(({{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000}) >> XLEN);
`endif
               if (reject) begin
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d     = StReq0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_we;
                  mem_addr_d  = {req_addr[AW-1:OFF_W], {OFF_W{1'b0}}};
                  mem_be_d    = BYTES'(mask_base << req_off);
                  mem_wdata_d = XLEN'({{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000});
               end
            end
         end
         StReq0: begin
            if (mem_gnt) begin
               state_d   = StWait0;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         StWait0: begin
            if (mem_rvalid) begin
`ifdef LSU_MISALIGN_EN
               lo_d = mem_rdata;
`endif
               if (mem_err) begin
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
`ifdef LSU_MISALIGN_EN
               end else if (split_q) begin
                  state_d     = StReq1;
                  mem_req_d   = 1'b1;
                  mem_we_d    = we_q;
                  mem_addr_d  = mem_addr_q + AW'(BYTES);
                  mem_be_d    = be_hi_q;
                  mem_wdata_d = wdata_hi_q;
`endif
               end else begin
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = we_q ? '0 : ld_ext;
               end
            end
         end
`ifdef LSU_MISALIGN_EN
         StReq1: begin
            if (mem_gnt) begin
               state_d   = StWait1;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         StWait1: begin
            if (mem_rvalid) begin
               state_d     = StResp;
               rsp_valid_d = 1'b1;
               rsp_err_d   = mem_err;
               rsp_rdata_d = (we_q || mem_err) ? '0 : ld_ext;
            end
         end
`endif
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         we_q        <= 1'b0;
         size_q      <= 4'd1;
         sgn_q       <= 1'b0;
         off_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_EN
         split_q     <= 1'b0;
         be_hi_q     <= '0;
         wdata_hi_q  <= '0;
         lo_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         sgn_q       <= sgn_d;
         off_q       <= off_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_MISALIGN_EN
         split_q     <= split_d;
         be_hi_q     <= be_hi_d;
         wdata_hi_q  <= wdata_hi_d;
         lo_q        <= lo_d;
`endif
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/lsu_seq.md
Name: lsu_seq

Overview:
- Parametrised, multi-cycle load/store unit placed between the execute stage and a data memory port with a request/grant/response handshake.
- Generates byte enables and aligns store data for XLEN-wide memory words.
- Extracts and sign- or zero-extends load data.
- Optionally splits accesses that cross a word boundary into two memory beats.
- Holds one access in flight at a time.

Parameters:
- XLEN, 32, data and memory word width in bits; legal values 32 or 64. BYTES = XLEN/8, OFF_W = log2(BYTES).
- AW, 32, byte address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  LSU can accept an access (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width/sign code.
- req_addr  in  AW  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  one-cycle pulse; access complete. There is no backpressure.
- rsp_rdata  out  XLEN  extended load result; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid: illegal funct3, misalignment, or memory error.
- mem_req  out  1  memory request.
- mem_gnt  in  1  request accepted this cycle.
- mem_we  out  1  write.
- mem_addr  out  AW  word-aligned address (low OFF_W bits are 0).
- mem_be  out  BYTES  byte enables.
- mem_wdata  out  XLEN  lane-aligned store data.
- mem_rvalid  in  1  response for a granted beat; writes are responded to as well.
- mem_rdata  in  XLEN  read word.
- mem_err  in  1  bus error, qualified by mem_rvalid.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - req_ready = 1.
  - mem_req, mem_we, rsp_valid and rsp_err go to 0.
  - mem_addr, mem_be, mem_wdata and rsp_rdata go to 0.
  - Reset during any state abandons the access. Any later mem_rvalid is ignored while in IDLE.
- Size decode:
  - Size 1: 000 (LB), 100 (LBU).
  - Size 2: 001 (LH), 101 (LHU).
  - Size 4: 010 (LW).
  - Size 8: 011 (LD) and 110 (LWU, size 4 unsigned) are legal only when XLEN=64.
  - Any other code is illegal. Stores use only 000, 001, 010 and 011; any other store code is illegal.
- Address terms: off = req_addr[OFF_W-1:0]. An access is split when off + size > BYTES.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - On req_valid, latch the request.
  - Illegal code: go to RESP with err=1; no memory access.
  - Legal code: go to REQ0.
- REQ0:
  - mem_req = 1.
  - mem_addr = aligned address; mem_be = ((1<<size)-1) << off, truncated to BYTES.
  - mem_wdata = wdata << 8*off.
  - Hold every mem_* output stable until mem_gnt, then go to WAIT0.
- WAIT0:
  - On mem_rvalid, capture mem_rdata into the low beat.
  - If mem_err: go to RESP with err=1, and skip beat 1.
  - Else if split: go to REQ1.
  - Else: go to RESP.
- REQ1:
  - mem_addr = aligned address + BYTES, with AW-bit wrap-around.
  - mem_be = spill enables (upper bits of the 2*BYTES-wide shifted mask).
  - mem_wdata = upper XLEN bits of the 2*XLEN-wide shifted data.
  - Wait for mem_gnt, then go to WAIT1.
- WAIT1: capture the high beat; mem_err sets err; go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then return to IDLE.
- Load result:
  - Form {high beat, low beat} >> 8*off and take the low size bytes.
  - Signed codes extend from the MSB of the extracted field; unsigned codes zero-extend.
- Latency: request accepted at edge N; mem_req is high in cycle N+1; grant in the same cycle and rvalid one cycle later give rsp_valid in cycle N+3. Split accesses add at least 2 cycles.
- mem_rvalid is ignored in REQ states and in IDLE. Stalled grants stretch REQx indefinitely.

Optional Feature:
- Macro LSU_MISALIGN_EN.
- Defined: split accesses take the two-beat path described above.
- Undefined:
  - Any split access goes directly to RESP with rsp_err = 1; no memory request is issued.
  - REQ1 and WAIT1 are not synthesised.
  - Alignment within a word (e.g. a halfword at off=1 when XLEN=32) is still serviced in a single beat.

Test Plan:
- LB at address 0x103, XLEN=32, mem_rdata 0x80FF_1234, grant immediate -> mem_be 4'b1000; rsp_rdata 0xFFFF_FF80 in cycle N+3; rsp_err 0.
- SH at 0x202, req_wdata 0xDEAD_BEEF -> mem_addr 0x200, mem_be 4'b1100, mem_wdata 0xBEEF_0000.
- LW at 0x0FE with LSU_MISALIGN_EN defined, reads 0xAABB_CCDD then 0x1122_3344 -> beats at 0x0FC (be 1100) and 0x100 (be 0011); rsp_rdata 0x3344_AABB. Without the macro: no mem_req, rsp_err 1.
- Grant held low for 5 cycles during REQ0 -> mem_addr, mem_be and mem_wdata stay constant; rsp_valid only after rvalid.
- Load with funct3 011 at XLEN=32 -> rsp_err 1 and no mem_req. mem_err on beat 0 of a split access -> no second beat; rsp_err 1.
- rst_n asserted low in WAIT0 -> mem_req 0 immediately; state IDLE; a late mem_rvalid produces no rsp_valid.
